// File: rtl/sdc_pkg.sv
// Shared types and parameter defaults for the SDC closing sequencer.
package sdc_pkg;

   typedef enum logic [2:0] {
      StInit      = 3'd0,
      StWaitReady = 3'd1,
      StArmed     = 3'd2,
      StClosing   = 3'd3,
      StClosed    = 3'd4,
      StEmergency = 3'd5
   } sdc_state_e;

   localparam int unsigned DefDebounceCycles = 4;
   localparam int unsigned DefWdTimeout      = 16;
   localparam int unsigned DefCloseTimeout   = 32;

endpackage

// File: rtl/sdc_debounce.sv
// Activation-button debouncer: qualifies the mode-selected button and emits a
// single-cycle pulse once it has been sampled high DEBOUNCE_CYCLES times in a row.
module sdc_debounce
   import sdc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic mode_i,
   input  logic btn_cockpit_i,
   input  logic btn_external_i,
   output logic act_evt_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mode_prev_q;
   logic            act_q, act_d;
   logic            btn;

   assign btn = mode_i ? btn_external_i : btn_cockpit_i;

   always_comb begin
      cnt_d = cnt_q;
      // A mode switch restarts qualification so a half-pressed old button cannot carry over.
      if ((mode_i != mode_prev_q) || !btn) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 1'b1;
      end
      act_d = (cnt_d == CntMax) && (cnt_q != CntMax);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         mode_prev_q <= mode_i;
         act_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         mode_prev_q <= mode_i;
         act_q       <= act_d;
      end
   end

   assign act_evt_o = act_q;

endmodule

// File: rtl/sdc_sequencer.sv
// Shutdown-circuit closing sequencer: arms on a live watchdog and intact chain,
// closes the relay on a debounced activation and latches any fault into EMERGENCY.
module sdc_sequencer
   import sdc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned WD_TIMEOUT      = DefWdTimeout,
   parameter int unsigned CLOSE_TIMEOUT   = DefCloseTimeout
) (
   input  logic       clk,
   input  logic       Power_on_Reset,
   input  logic       AS_driving_mode,
   input  logic       TS_Activation_Button_cockpit,
   input  logic       TS_Activation_Button_external,
   input  logic       AS_close_SDC,
   input  logic       Watchdog,
   input  logic       Shutdown_circuit,
   input  logic       SDC_sense,
   output logic       To_SDC_relais,
   output logic       SDC_is_Ready,
   output logic       Emergency,
   output logic [2:0] State_code
);

   localparam int unsigned WdW    = $clog2(WD_TIMEOUT + 1);
   localparam int unsigned CloseW = $clog2(CLOSE_TIMEOUT + 1);
   localparam logic [WdW-1:0]    WdMax    = WdW'(WD_TIMEOUT);
   localparam logic [CloseW-1:0] CloseMax = CloseW'(CLOSE_TIMEOUT);

   sdc_state_e        state_q, state_d;
   logic [WdW-1:0]    wd_cnt_q, wd_cnt_d;
   logic [CloseW-1:0] close_cnt_q, close_cnt_d;
   logic [CloseW-1:0] close_inc;
   logic              wd_prev_q;
   logic              mode_prev_q;
   logic              wd_ok;
   logic              close_to;
   logic              mode_chg;
   logic              act_evt;

   sdc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i         (clk),
      .rst_i         (Power_on_Reset),
      .mode_i        (AS_driving_mode),
      .btn_cockpit_i (TS_Activation_Button_cockpit),
      .btn_external_i(TS_Activation_Button_external),
      .act_evt_o     (act_evt)
   );

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (Watchdog != wd_prev_q) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WdMax) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   assign wd_ok     = (wd_cnt_q < WdMax);
   assign mode_chg  = (AS_driving_mode != mode_prev_q);
   assign close_inc = close_cnt_q + 1'b1;
   // Timeout fires as the count reaches the limit, so CLOSING lasts exactly CLOSE_TIMEOUT cycles.
   assign close_to  = (close_inc >= CloseMax);

   always_comb begin
      state_d     = state_q;
      close_cnt_d = close_cnt_q;
      unique case (state_q)
         StInit: state_d = StWaitReady;
         StWaitReady: begin
            if (wd_ok && Shutdown_circuit) state_d = StArmed;
         end
         StArmed: begin
            if (!wd_ok || !Shutdown_circuit) begin
               state_d = StWaitReady;
            end else if (act_evt && AS_close_SDC) begin
               state_d     = StClosing;
               close_cnt_d = '0;
            end
         end
         StClosing: begin
            close_cnt_d = close_inc;
            if (close_to || !wd_ok || !Shutdown_circuit) begin
               state_d = StEmergency;
            end else if (SDC_sense && (close_cnt_q < CloseMax)) begin
               state_d = StClosed;
            end
         end
         StClosed: begin
            if (!wd_ok || !Shutdown_circuit || !SDC_sense || !AS_close_SDC || mode_chg) begin
               state_d = StEmergency;
            end
         end
         StEmergency: state_d = StEmergency;
         default: state_d = StEmergency;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Power_on_Reset) begin
         state_q     <= StInit;
         wd_cnt_q    <= WdMax;
         close_cnt_q <= '0;
         wd_prev_q   <= 1'b0;
         mode_prev_q <= AS_driving_mode;
      end else begin
         state_q     <= state_d;
         wd_cnt_q    <= wd_cnt_d;
         close_cnt_q <= close_cnt_d;
         wd_prev_q   <= Watchdog;
         mode_prev_q <= AS_driving_mode;
      end
   end

   assign To_SDC_relais = (state_q == StClosing) || (state_q == StClosed);
   assign SDC_is_Ready  = (state_q == StArmed);
   assign Emergency     = (state_q == StEmergency);
   assign State_code    = state_q;

endmodule
